// File: rtl/mux_alu_b.sv
// ALU operand-B selector for the execute stage.
// Registers Operator ? B : A with enable and synchronous reset.
module mux_alu_b #(
  parameter int unsigned           WIDTH       = 32,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Operator,
  output logic [WIDTH-1:0] MUX_Alu_B_Result
);

  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;

  // Ternary keeps an unknown select visible as X on differing bits.
  always_comb begin
    result_d = result_q;
    if (en) result_d = Operator ? B : A;
  end

  always_ff @(posedge clk) begin
    if (rst) result_q <= RESET_VALUE;
    else     result_q <= result_d;
  end

  assign MUX_Alu_B_Result = result_q;

endmodule

// File: tb/tb_mux_alu_b.sv
// Self-checking bench for mux_alu_b.
// Directed steps plus random traffic against a reference model.
module tb_mux_alu_b;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] A;
  logic [31:0] B;
  logic        Operator;
  logic [31:0] MUX_Alu_B_Result;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model;
  int          op_int;

  mux_alu_b #(.WIDTH(32), .RESET_VALUE(32'h0)) dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .A                (A),
    .B                (B),
    .Operator         (Operator),
    .MUX_Alu_B_Result (MUX_Alu_B_Result)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] exp, input string tag);
    checks++;
    assert (MUX_Alu_B_Result === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, MUX_Alu_B_Result, exp);
    end
  endtask

  // Drive one cycle, advance the model by the block's rules, compare.
  task automatic step(input logic r, input logic e, input logic o,
                      input logic [31:0] a, input logic [31:0] b,
                      input string tag);
    @(negedge clk);
    rst = r; en = e; Operator = o; A = a; B = b;
    @(posedge clk);
    #1;
    if (r)      model = 32'h0;
    else if (e) model = o ? b : a;
    chk(model, tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; Operator = 1'b1;
    A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    model = 32'h0;

    step(1, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "reset0");
    step(1, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "reset1");
    step(0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "first_load");

    step(0, 1, 1, 32'h0000_0001, 32'h0000_0000, "sel_b");
    step(0, 1, 0, 32'h0000_0001, 32'h0000_0000, "sel_a");
    step(0, 1, 0, 32'h0000_0000, 32'h0000_0001, "swap_a");
    op_int = 5;
    step(0, 1, op_int[0], 32'h0000_0000, 32'h0000_0001, "int5_sel_b");

    step(0, 1, 0, 32'h1234_5678, 32'hDEAD_BEEF, "stall_load");
    step(0, 0, 1, 32'h1111_1111, 32'h2222_2222, "stall1");
    step(0, 0, 0, 32'h3333_3333, 32'h4444_4444, "stall2");
    step(0, 0, 1, 32'h5555_5555, 32'h6666_6666, "stall3");
    chk(32'h1234_5678, "stall_hold");
    step(0, 1, 1, 32'h5555_5555, 32'h6666_6666, "stall_release");

    step(1, 1, 1, 32'hCAFE_F00D, 32'hBEEF_CAFE, "rst_wins");
    chk(32'h0, "rst_zero");
    for (int i = 0; i < 8; i++)
      step(0, 1, i[0], 32'hAAAA_AAAA, 32'h5555_5555, "alternate");

    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom), $urandom, $urandom, "random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
